// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the PC to a combinational instruction memory and buffers
// fetched {pc, word} pairs in a small FIFO for decode. Optional halt detection: IFU_HALT_DETECT_EN.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic [31:0]                imem_addr,
   input  logic [31:0]                imem_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_instr,
   output logic [31:0]                out_pc,
   input  logic                       redirect_valid,
   input  logic [31:0]                redirect_pc,
   output logic [$clog2(DEPTH):0]     fill_level,
   output logic                       halted
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [31:0]   r_pc;
   logic [31:0]   r_pc_next;
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_count_next;
   logic [31:0]   r_instr_mem [DEPTH];
   logic [31:0]   r_pc_mem    [DEPTH];

   logic          w_pop;
   logic          w_push;
   logic          w_halted;
   logic          w_halt_hit;
   logic [31:0]   w_redirect_pc;

   assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

`ifdef IFU_HALT_DETECT_EN
   logic r_halted;

   assign w_halted   = r_halted;
   assign w_halt_hit = w_push && (imem_data == 32'h0000_0063);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_halted <= 1'b0;
      end else if (redirect_valid) begin
         r_halted <= 1'b0;
      end else if (w_halt_hit) begin
         r_halted <= 1'b1;
      end
   end
`else
   assign w_halted   = 1'b0;
   assign w_halt_hit = 1'b0;
`endif

   assign halted     = w_halted;
   assign imem_addr  = r_pc;
   assign fill_level = r_count;
   assign out_valid  = (r_count != '0);
   assign out_instr  = out_valid ? r_instr_mem[r_rd_ptr] : 32'h0;
   assign out_pc     = out_valid ? r_pc_mem[r_rd_ptr] : 32'h0;

   // A same-cycle pop frees a slot, so a full buffer still sustains one fetch per cycle.
   assign w_pop  = out_valid && out_ready;
   assign w_push = !redirect_valid && !w_halted && ((r_count < FULL_COUNT) || w_pop);

   always_comb begin
      r_pc_next    = r_pc;
      r_count_next = r_count;
      if (redirect_valid) begin
         r_pc_next    = w_redirect_pc;
         r_count_next = '0;
      end else begin
         // The halting word is buffered, but the PC stays parked on it.
         if (w_push && !w_halt_hit) begin
            r_pc_next = r_pc + 32'd4;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count_next = r_count + CW'(1);
            2'b01:   r_count_next = r_count - CW'(1);
            default: r_count_next = r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc     <= RESET_PC;
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         r_pc    <= r_pc_next;
         r_count <= r_count_next;
         if (redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
         end else begin
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + AW'(1);
            end
         end
      end
   end

   // Payload storage needs no reset: the head is masked to 0 whenever the buffer is empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_instr_mem[r_wr_ptr] <= imem_data;
         r_pc_mem[r_wr_ptr]    <= r_pc;
      end
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface: holds the PC, drives the word address to the instruction memory, and captures the returned word.
- Buffers fetched words with their PCs in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts control-flow redirects (branch/jal target) from execute, which flush the buffer.
- Sits between instruction_memory (combinational read: data valid in the same cycle as the address) and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, buffer entries; power of 2, minimum 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  byte address to instruction memory; always equals the pc register.
- imem_data  in  32  instruction word for imem_addr, same cycle.
- out_valid  out  1  buffer head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  instruction at buffer head.
- out_pc  out  32  PC of the instruction at buffer head.
- redirect_valid  in  1  load a new PC and flush the buffer.
- redirect_pc  in  32  new PC; bits [1:0] are ignored and treated as 0.
- fill_level  out  $clog2(DEPTH)+1  number of occupied entries.
- halted  out  1  fetch stopped; driven only with the optional feature, otherwise tied 0.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; buffer empty; rd/wr pointers 0.
  - out_valid=0, out_instr=0, out_pc=0, fill_level=0, halted=0.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Combinational outputs:
  - imem_addr=pc.
  - out_valid=(fill_level!=0).
  - out_instr/out_pc come from the head entry and are 0 when empty.
- Pop: occurs on a rising edge when out_valid && out_ready.
- Push: occurs on a rising edge when !redirect_valid && !halted && (fill_level<DEPTH || pop this cycle).
  - Writes {pc, imem_data} at the tail.
  - pc <= pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- Push and pop in the same cycle: both happen and fill_level is unchanged. This is legal when full, giving one instruction per cycle sustained.
- Full with no pop: no push; pc holds; imem_addr is stable.
- Redirect (redirect_valid=1 at the edge):
  - Buffer is flushed (fill_level=0, pointers 0), overriding any same-cycle pop or push.
  - pc <= {redirect_pc[31:2],2'b00}.
  - The fetched count from the new target starts on the next edge.
  - Redirect takes priority over every other event, including halted (it clears halted).
- Latency: an instruction fetched on edge N is visible at out_* after edge N, so it can be consumed at edge N+1.
  - After reset release, the first edge pushes RESET_PC; out_valid rises after that edge.
- Empty with out_ready=1: no pop, no underflow, pointers unchanged.
- FIFO implementation: DEPTH-entry register array, wrap-around pointers of $clog2(DEPTH) bits, separate count register.

Optional Feature:
- IFU_HALT_DETECT_EN defined:
  - When a pushed word equals 32'h0000_0063 (beq x0,x0,0 self-loop), the word is still pushed and then halted<=1.
  - Further pushes stop and pc holds at the halting PC.
  - halted clears only on reset or redirect.
- Undefined: halted is tied 0; the self-loop word is fetched repeatedly like any other instruction.

Test Plan:
- Reset release with RESET_PC=0 and memory words 0x33, 0x00020103, 0x00340023, out_ready=1: out_pc shows 0,4,8 on consecutive cycles with matching out_instr; out_valid rises one edge after release.
- out_ready=0 for 5 cycles: fill_level reaches 2 and sticks; imem_addr holds at 8. Then out_ready=1: pops PC 0,4,8 in order with no loss or duplicates.
- Full buffer with out_ready=1 and redirect_valid=1, redirect_pc=0x32 in the same cycle: next cycle fill_level=0 and imem_addr=0x30; the following edge pushes PC 0x30.
- pc=32'hFFFF_FFFC, free-running: next pushed PC is 0x0000_0000.
- Async reset pulse mid-cycle while fill_level=2: out_valid and fill_level drop to 0 immediately, before the next edge.
- With IFU_HALT_DETECT_EN and word 0x00000063 at address 0x34: entry 0x34 is delivered, halted=1, and imem_addr stays at 0x34. A redirect to 0 clears halted and fetch resumes.
